// File: rtl/vec_issue_pkg.sv
// Shared types for the scalar-to-vector issue bridge.
// Holds the FSM state enum and the captured instruction payload struct.
// The scalar width matches XLEN of vector_processor_defs.svh (32).
package vec_issue_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCheck,
    StWaitAck,
    StWb
  } vec_issue_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic            wb_req;
  } issue_payload_t;

endpackage

// File: rtl/vec_issue_watchdog.sv
// Issue watchdog: counts cycles spent waiting on the vector processor and flags expiry.
// Only built when VEC_ISSUE_TIMEOUT_EN is defined; otherwise this file is empty.
// Ports:
//   clk, reset (async, active low)
//   clear    - zero the counter (taken on the edge that enters ISSUE)
//   count_en - bridge is in ISSUE or WAIT_ACK
//   expired  - counter has reached TIMEOUT_CYCLES while counting (combinational)
`ifdef VEC_ISSUE_TIMEOUT_EN
module vec_issue_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q;
    logic            at_limit;

    assign at_limit = (cnt_q == Limit);
    assign expired  = count_en && at_limit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en && !at_limit) begin
            // Saturate so a stray hold in the limit never wraps back to quiet.
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/vec_issue_bridge.sv
// Scalar-side bridge that hands one vector instruction at a time to the vector processor.
// Captures instruction + rs1/rs2, stalls the scalar pipeline until the vector side acks,
// and returns csr_out as a scalar writeback for vsetvl-family instructions.
// Optional watchdog: define VEC_ISSUE_TIMEOUT_EN to enable the TIMEOUT_CYCLES limit.
// Ports:
//   clk, reset (async, active low)
//   sp_*            - scalar pipeline request and operands
//   issue_stall     - hold the scalar pipeline (high outside IDLE)
//   inst_valid, instruction, rs1_data, rs2_data, vec_pro_ready - issue handshake
//   is_vec          - legality from the vector decoder, sampled in CHECK
//   vec_pro_ack, csr_out, scalar_pro_ready - completion handshake
//   wb_valid, wb_rd_addr, wb_data - one-cycle scalar writeback
//   illegal_inst, timeout_err     - one-cycle error pulses
module vec_issue_bridge
    import vec_issue_pkg::*;
`ifdef VEC_ISSUE_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
)
`endif
(
    input  logic            clk,
    input  logic            reset,
    input  logic            sp_vec_valid,
    input  logic [XLEN-1:0] sp_instruction,
    input  logic [XLEN-1:0] sp_rs1_data,
    input  logic [XLEN-1:0] sp_rs2_data,
    input  logic [4:0]      sp_rd_addr,
    input  logic            sp_wb_req,
    output logic            issue_stall,
    output logic            inst_valid,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            vec_pro_ready,
    input  logic            is_vec,
    input  logic            vec_pro_ack,
    input  logic [XLEN-1:0] csr_out,
    output logic            scalar_pro_ready,
    output logic            wb_valid,
    output logic [4:0]      wb_rd_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal_inst,
    output logic            timeout_err
);

    vec_issue_state_e state_q, state_d;
    issue_payload_t   payload_q;
    logic [XLEN-1:0]  wb_data_q;
    logic             expired;
    logic             capture;

    assign capture = (state_q == StIdle) && sp_vec_valid;

`ifdef VEC_ISSUE_TIMEOUT_EN
    logic wd_count;
    assign wd_count = (state_q == StIssue) || (state_q == StWaitAck);

    vec_issue_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (capture),
        .count_en(wd_count),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    assign timeout_err = expired;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; watchdog expiry beats any same-cycle handshake or ack.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (sp_vec_valid) state_d = StIssue;
            StIssue: begin
                if (expired)            state_d = StIdle;
                else if (vec_pro_ready) state_d = StCheck;
            end
            StCheck:   state_d = is_vec ? StWaitAck : StIdle;
            StWaitAck: begin
                if (expired)          state_d = StIdle;
                else if (vec_pro_ack) state_d = payload_q.wb_req ? StWb : StIdle;
            end
            StWb:      state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output decode.
    always_comb begin
        issue_stall      = (state_q != StIdle);
        inst_valid       = 1'b0;
        scalar_pro_ready = 1'b0;
        wb_valid         = 1'b0;
        illegal_inst     = 1'b0;
        unique case (state_q)
            StIssue:   inst_valid       = !expired;
            StCheck:   illegal_inst     = !is_vec;
            StWaitAck: scalar_pro_ready = 1'b1;
            StWb:      wb_valid         = 1'b1;
            default:   ;
        endcase
    end

    // Payload and writeback data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            payload_q <= '0;
            wb_data_q <= '0;
        end else begin
            if (capture) begin
                payload_q <= '{instruction: sp_instruction,
                               rs1_data:    sp_rs1_data,
                               rs2_data:    sp_rs2_data,
                               rd_addr:     sp_rd_addr,
                               wb_req:      sp_wb_req};
            end
            if ((state_q == StWaitAck) && vec_pro_ack && payload_q.wb_req && !expired) begin
                wb_data_q <= csr_out;
            end
        end
    end

    assign instruction = payload_q.instruction;
    assign rs1_data    = payload_q.rs1_data;
    assign rs2_data    = payload_q.rs2_data;
    assign wb_rd_addr  = payload_q.rd_addr;
    assign wb_data     = wb_data_q;

endmodule

// File: doc/vec_issue_bridge.md
Name: vec_issue_bridge

Overview:
Scalar-core-side bridge that hands vector instructions to vector_processor over the inst_valid/vec_pro_ready/vec_pro_ack handshake. It captures one vector instruction plus rs1/rs2 operands from the scalar pipeline, stalls the pipeline until the vector processor acknowledges, and returns csr_out (vsetvl/vsetvli result) as a scalar register writeback. It sits directly upstream of the vector processor's instruction queue, and it flags illegal vector encodings via is_vec.

Parameters:
XLEN, 32, scalar data/instruction width (from `XLEN in vector_processor_defs.svh)
TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with VEC_ISSUE_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
sp_vec_valid  in  1  scalar pipeline presents a vector instruction
sp_instruction  in  XLEN  instruction word
sp_rs1_data  in  XLEN  scalar rs1 operand
sp_rs2_data  in  XLEN  scalar rs2 operand
sp_rd_addr  in  5  scalar destination register
sp_wb_req  in  1  instruction writes scalar rd (vsetvl family)
issue_stall  out  1  stall scalar pipeline
inst_valid  out  1  to vector_processor: payload valid
instruction  out  XLEN  to vector_processor
rs1_data  out  XLEN  to vector_processor
rs2_data  out  XLEN  to vector_processor
vec_pro_ready  in  1  vector processor can accept
is_vec  in  1  vector processor decodes current instruction as legal
vec_pro_ack  in  1  vector processor finished instruction
csr_out  in  XLEN  CSR read result
scalar_pro_ready  out  1  bridge ready to take ack/result
wb_valid  out  1  one-cycle scalar writeback strobe
wb_rd_addr  out  5  writeback destination
wb_data  out  XLEN  writeback data
illegal_inst  out  1  one-cycle pulse: instruction rejected
timeout_err  out  1  one-cycle pulse: watchdog expired (0 when feature off)

Behaviour:
- Reset (async, reset==0): state IDLE; all outputs 0, payload/rd/wb_req registers 0, watchdog counter 0. Reset mid-transaction abandons it; no ack or writeback is produced afterwards.
- FSM states: IDLE, ISSUE, CHECK, WAIT_ACK, WB.
- IDLE: issue_stall=0. If sp_vec_valid=1 on a clock edge, capture instruction/rs1/rs2/rd/wb_req, go to ISSUE. Capture latency is 1 cycle.
- ISSUE: inst_valid=1 and payload held stable. Transfer occurs in a cycle with inst_valid & vec_pro_ready; then go to CHECK. While vec_pro_ready=0, stay in ISSUE with payload unchanged.
- CHECK (one cycle): instruction outputs still driven; sample is_vec. If is_vec=0, pulse illegal_inst and go to IDLE with no ack wait. Otherwise go to WAIT_ACK.
- WAIT_ACK: scalar_pro_ready=1. On vec_pro_ack=1: if wb_req, latch csr_out into wb_data and go to WB; else go to IDLE.
- WB: wb_valid=1 for exactly one cycle, with wb_rd_addr=captured rd (rd==0 still strobes, the regfile discards it); then go to IDLE.
- inst_valid=1 only in ISSUE. scalar_pro_ready=1 only in WAIT_ACK. issue_stall=1 in every state except IDLE.
- vec_pro_ack outside WAIT_ACK is ignored. is_vec outside CHECK is ignored.
- sp_vec_valid while issue_stall=1 is ignored; the pipeline holds it.
- Back-to-back: a new instruction is accepted in the IDLE cycle immediately after WB or WAIT_ACK exit. Minimum turnaround is 5 cycles with wb, 4 without.

Optional Feature:
VEC_ISSUE_TIMEOUT_EN defined:
- A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entry to ISSUE and increments in ISSUE and WAIT_ACK.
- When it reaches TIMEOUT_CYCLES, pulse timeout_err, drop inst_valid, and go to IDLE. No writeback.
- Expiry takes precedence over a same-cycle ack or handshake.

Not defined: no counter; timeout_err tied 0; the FSM waits indefinitely.

Decomposition:
- Package vec_issue_pkg: state enum vec_issue_state_e, and struct issue_payload_t {instruction, rs1_data, rs2_data, rd_addr[4:0], wb_req}. XLEN stays in vector_processor_defs.svh.
- One natural sub-module: vec_issue_watchdog (counter + expiry pulse), instantiated only under VEC_ISSUE_TIMEOUT_EN.

Test Plan:
- Reset mid-ISSUE (inst_valid=1), deassert reset -> all outputs 0, state IDLE, no later wb_valid.
- sp_instruction=0x0C0572D7 (vsetvli), rs1=8, rd=5, wb_req=1, vec_pro_ready=1, is_vec=1, ack 3 cycles later with csr_out=8 -> inst_valid high 1 cycle, one wb_valid with wb_rd_addr=5, wb_data=8, then issue_stall=0.
- vec_pro_ready low for 4 cycles after capture -> inst_valid held 4+1 cycles with payload unchanged and exactly one transfer.
- Illegal word 0xFFFFFFFF, is_vec=0 in CHECK -> illegal_inst single pulse, no wb_valid, IDLE next cycle, and ack pulses are ignored.
- Vector load (wb_req=0) followed by second instruction held on sp_vec_valid -> second captured on the IDLE cycle right after ack, with no wb_valid for the first.
- VEC_ISSUE_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> timeout_err pulse 16 cycles after ISSUE entry, state IDLE, issue_stall=0; without macro, timeout_err stays 0 for 100 cycles.
